// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon player-side logic.
package simon_pkg;

  localparam int unsigned MAX_LEN  = 10;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned NOTE_W   = 2;
  localparam int unsigned NUM_BTNS = 4;

  typedef logic [NOTE_W-1:0] note_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE
  } chk_state_e;

  function automatic logic is_onehot(input logic [NUM_BTNS-1:0] v);
    return (v != '0) && ((v & (v - NUM_BTNS'(1))) == '0);
  endfunction

  // Only meaningful for one-hot inputs; highest set bit wins otherwise.
  function automatic note_t onehot_to_note(input logic [NUM_BTNS-1:0] v);
    note_t n;
    n = '0;
    for (int k = 0; k < NUM_BTNS; k++) begin
      if (v[k]) n = NOTE_W'(k);
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Button front end: 2-FF synchroniser, stability counter, one-hot decode
// and a one-cycle press pulse on the rising edge of player_pressed.
module btn_debouncer
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btns,
  output logic [NOTE_W-1:0]   player_num,
  output logic                player_pressed,
  output logic                press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTNS-1:0] sync1_q, sync2_q;
  logic [NUM_BTNS-1:0] db_q, db_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  note_t               num_q, num_d;
  logic                pressed_q, pressed_d;
  logic                press_q, press_d;

  // sync1 != sync2 means sync2 is about to take a new pattern this edge.
  always_comb begin
    cnt_d     = cnt_q;
    db_d      = db_q;
    num_d     = num_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;

    if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (cnt_q == CNT_MAX) begin
      db_d = sync2_q;
    end

    pressed_d = is_onehot(db_d);
    if (pressed_d) begin
      num_d = onehot_to_note(db_d);
    end
    press_d = pressed_d & ~pressed_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      db_q      <= '0;
      num_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= btns;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      num_q     <= num_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
    end
  end

  assign player_num     = num_q;
  assign player_pressed = pressed_q;
  assign press          = press_q;

endmodule

// File: rtl/simon_response_checker.sv
// Checks the player's button entries against the stored Simon sequence and
// reports round success, a wrong note, or a response timeout.
module simon_response_checker
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000,
  parameter int unsigned MAX_LEN         = simon_pkg::MAX_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btns,
  input  logic                start,
  input  logic [IDX_W-1:0]    round_len,
  output logic [IDX_W-1:0]    exp_addr,
  input  logic [NOTE_W-1:0]   exp_num,
  output logic [NOTE_W-1:0]   player_num,
  output logic                player_pressed,
  output logic                busy,
  output logic                round_ok,
  output logic                mistake,
  output logic                timeout
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

  note_t deb_num;
  logic  deb_pressed;
  logic  deb_press;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debouncer (
    .clk           (clk),
    .reset         (reset),
    .btns          (btns),
    .player_num    (deb_num),
    .player_pressed(deb_pressed),
    .press         (deb_press)
  );

  chk_state_e       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             busy_q;
  logic             round_ok_q, round_ok_d;
  logic             mistake_q, mistake_d;
  logic             timeout_q, timeout_d;
  logic             len_valid;

  assign len_valid = (round_len != '0) && (32'(round_len) <= MAX_LEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Index returns to 0 whenever the round ends so exp_addr idles at 0.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    len_d      = len_q;
    timer_d    = timer_q;
    round_ok_d = 1'b0;
    mistake_d  = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && len_valid) begin
          len_d   = round_len;
          index_d = '0;
          timer_d = '0;
          state_d = WAIT_PRESS;
        end
      end

      WAIT_PRESS: begin
        if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_W'(1);
        end
        // A press in the same cycle as expiry takes priority.
        if (deb_press) begin
          if (deb_num != exp_num) begin
            mistake_d = 1'b1;
            index_d   = '0;
            state_d   = IDLE;
          end else begin
            state_d = WAIT_RELEASE;
          end
        end else if (timer_q == TMR_MAX) begin
          timeout_d = 1'b1;
          index_d   = '0;
          state_d   = IDLE;
        end
      end

      WAIT_RELEASE: begin
        if (!deb_pressed) begin
          if (index_q == len_q - IDX_W'(1)) begin
            round_ok_d = 1'b1;
            index_d    = '0;
            state_d    = IDLE;
          end else begin
            index_d = index_q + IDX_W'(1);
            timer_d = '0;
            state_d = WAIT_PRESS;
          end
        end
      end

      default: begin
        index_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q    <= '0;
      len_q      <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      round_ok_q <= 1'b0;
      mistake_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      index_q    <= index_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      busy_q     <= (state_d != IDLE);
      round_ok_q <= round_ok_d;
      mistake_q  <= mistake_d;
      timeout_q  <= timeout_d;
    end
  end

  assign exp_addr       = index_q;
  assign player_num     = deb_num;
  assign player_pressed = deb_pressed;
  assign busy           = busy_q;
  assign round_ok       = round_ok_q;
  assign mistake        = mistake_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_simon_response_checker.sv
// Scoreboard bench: stimulus queues expected flag events, a negedge monitor
// pops and compares them; state/output spot checks are made inline.
module tb_simon_response_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btns;
  logic       start;
  logic [3:0] round_len;
  logic [3:0] exp_addr;
  logic [1:0] exp_num;
  logic [1:0] player_num;
  logic       player_pressed;
  logic       busy;
  logic       round_ok;
  logic       mistake;
  logic       timeout;

  logic [1:0] mem [16];
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int kind;   // 1 round_ok, 2 mistake, 3 timeout
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign exp_num = mem[exp_addr];

  simon_response_checker #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btns          (btns),
    .start         (start),
    .round_len     (round_len),
    .exp_addr      (exp_addr),
    .exp_num       (exp_num),
    .player_num    (player_num),
    .player_pressed(player_pressed),
    .busy          (busy),
    .round_ok      (round_ok),
    .mistake       (mistake),
    .timeout       (timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [3:0] len, output int s);
    s = cyc;
    round_len = len;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic press_release(input logic [3:0] b);
    btns = b;
    tick(10);
    btns = 4'b0000;
    tick(10);
  endtask

  // Monitor: every flag pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    int kind;
    if (!reset && (round_ok || mistake || timeout)) begin
      kind = round_ok ? 1 : (mistake ? 2 : 3);
      chk("flags_exclusive", int'(round_ok) + int'(mistake) + int'(timeout), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_flag", kind, 0);
      end else begin
        e = exp_q.pop_front();
        chk("flag_kind", kind, e.kind);
        chk("flag_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int s;
    int c;
    int n_hi;
    reset = 1'b1;
    btns = 4'b0000;
    start = 1'b0;
    round_len = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;

    tick(1);
    chk("rst_exp_addr", int'(exp_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_player_num", int'(player_num), 0);
    chk("rst_player_pressed", int'(player_pressed), 0);
    chk("rst_flags", int'({round_ok, mistake, timeout}), 0);
    reset = 1'b0;
    tick(5);

    // Correct three-note round {2,0,3}
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    do_start(4'd3, s);
    chk("ok_busy_after_start", int'(busy), 1);
    chk("ok_addr0", int'(exp_addr), 0);
    btns = 4'b0100;
    tick(10);
    chk("ok_addr0_held", int'(exp_addr), 0);
    btns = 4'b0000;
    tick(10);
    chk("ok_addr1", int'(exp_addr), 1);
    press_release(4'b0001);
    chk("ok_addr2", int'(exp_addr), 2);
    btns = 4'b1000;
    tick(10);
    btns = 4'b0000;
    c = cyc;
    push_ev(1, c + 7);
    tick(6);
    chk("ok_busy_before_flag", int'(busy), 1);
    tick(1);
    chk("ok_busy_falls", int'(busy), 0);
    chk("ok_addr_idle", int'(exp_addr), 0);
    tick(5);

    // Wrong first note
    mem[0] = 2'd1;
    do_start(4'd4, s);
    btns = 4'b0001;
    c = cyc;
    push_ev(2, c + 7);
    tick(6);
    chk("mis_busy_at_press", int'(busy), 1);
    tick(1);
    chk("mis_busy_falls", int'(busy), 0);
    chk("mis_addr0", int'(exp_addr), 0);
    tick(3);
    btns = 4'b0000;
    tick(10);

    // Timeout with no presses, then a press produces nothing
    do_start(4'd2, s);
    push_ev(3, s + 101);
    tick(99);
    chk("to_busy_before", int'(busy), 1);
    tick(5);
    chk("to_busy_after", int'(busy), 0);
    press_release(4'b0010);
    chk("to_idle_after_press", int'(busy), 0);

    // Bounce filtering
    n_hi = 0;
    for (int i = 0; i < 5; i++) begin
      btns = 4'b0010;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (player_pressed) n_hi++;
      end
      btns = 4'b0000;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (player_pressed) n_hi++;
      end
    end
    chk("bounce_filtered", n_hi, 0);
    btns = 4'b0010;
    tick(5);
    chk("stable_not_yet", int'(player_pressed), 0);
    tick(1);
    chk("stable_pressed", int'(player_pressed), 1);
    chk("stable_num", int'(player_num), 1);
    tick(4);
    btns = 4'b0011;
    tick(5);
    chk("multi_not_yet", int'(player_pressed), 1);
    tick(1);
    chk("multi_not_pressed", int'(player_pressed), 0);
    chk("multi_num_held", int'(player_num), 1);
    btns = 4'b0000;
    tick(10);

    // Invalid round lengths
    do_start(4'd0, s);
    chk("len0_busy", int'(busy), 0);
    tick(2);
    chk("len0_busy_later", int'(busy), 0);
    do_start(4'd11, s);
    chk("len11_busy", int'(busy), 0);
    tick(2);

    // Second start mid-round, then reset mid-round with a button held
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    do_start(4'd3, s);
    press_release(4'b0100);
    chk("mid_addr1", int'(exp_addr), 1);
    do_start(4'd1, s);
    chk("restart_busy", int'(busy), 1);
    chk("restart_addr", int'(exp_addr), 1);
    tick(2);
    press_release(4'b0001);
    chk("mid_addr2", int'(exp_addr), 2);
    btns = 4'b1000;
    tick(10);
    chk("pre_rst_pressed", int'(player_pressed), 1);
    reset = 1'b1;
    #1;
    chk("arst_exp_addr", int'(exp_addr), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_pressed", int'(player_pressed), 0);
    chk("arst_num", int'(player_num), 0);
    chk("arst_flags", int'({round_ok, mistake, timeout}), 0);
    tick(1);
    reset = 1'b0;
    tick(5);
    chk("requal_not_yet", int'(player_pressed), 0);
    tick(1);
    chk("requal_pressed", int'(player_pressed), 1);
    chk("requal_num", int'(player_num), 3);
    chk("requal_idle", int'(busy), 0);
    btns = 4'b0000;
    tick(10);

    chk("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
